vec_lsu_addr_gen: RTL and testbench
===================================

Name: vec_lsu_addr_gen

Overview:
- Downstream of the vector instruction controller.
- Accepts one decoded vector load (mop, base, stride, vl, sew) and walks elements 0..vl-1.
- Issues one word-aligned memory read request per element with byte enables, and tracks outstanding responses.
- Signals completion to the vector load writeback path. Supports unit-stride (mop 00), indexed (mop 01/11) and strided (mop 10).

Parameters:
- XLEN, 32, scalar/address/data width.
- MAX_OUTST, 4, maximum in-flight memory requests (power of two, ≥1).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ld_valid  in  1  load command valid
- ld_ready  out  1  block idle, command accepted when ld_valid&&ld_ready
- ld_mop  in  2  vec_inst[27:26]
- ld_base  in  XLEN  rs1 scalar data (base address)
- ld_stride  in  XLEN  rs2 scalar data (byte stride, signed)
- ld_sew  in  2  00=8b, 01=16b, 10=32b, 11=illegal
- ld_vl  in  XLEN  element count from vec_csr
- elem_idx  out  XLEN  current element index (drives index-vector read)
- idx_offset  in  XLEN  index element value for elem_idx, valid same cycle, unsigned
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
- mem_byte_en  out  XLEN/8  byte lanes of the element
- mem_rsp_valid  in  1  one read response returned (in order)
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse, all elements issued and all responses returned
- err  out  1  one-cycle pulse with done on illegal sew or misaligned element

Behaviour:
- Reset (async, reset_n=0): state IDLE, ld_ready=1, mem_req_valid=0, done=0, err=0, busy=0, elem_idx=0, outstanding=0, mem_addr=0, mem_byte_en=0.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: ld_ready=1. On handshake, latch all ld_* fields and clear elem_idx and issued count.
  - If ld_vl==0 or ld_sew==11, go to FINISH (err=1 for sew==11).
  - Otherwise go to ISSUE. First request is valid the cycle after acceptance.
- Element address ea(i):
  - mop 00: base + i*(1<<sew).
  - mop 10: base + i*stride, computed by accumulation (addr += stride per accepted request), modulo 2^XLEN.
  - mop 01/11: base + idx_offset, evaluated combinationally each ISSUE cycle.
- Byte enables: (1<<(1<<sew))-1 shifted left by ea[1:0].
  - Misaligned element (16b with ea[0]=1, or 32b with ea[1:0]≠0): abort issuing, go to DRAIN, assert err with done.
- ISSUE:
  - mem_req_valid=1 when outstanding<MAX_OUTST. mem_addr and mem_byte_en stay stable while valid&&!ready.
  - On accept: elem_idx++ and outstanding++.
  - When the last element (elem_idx==vl-1) is accepted, go to DRAIN.
- Outstanding counter: request accept and mem_rsp_valid in the same cycle leave the count unchanged. mem_rsp_valid with outstanding==0 is ignored.
- DRAIN: no requests. When outstanding==0 (including the same-cycle response that brings it to 0), go to FINISH.
- FINISH: done=1 (err as latched) for exactly one cycle, then IDLE. ld_ready=0 in FINISH, so back-to-back commands are separated by at least one cycle.
- busy=1 in ISSUE, DRAIN and FINISH.
- Latency: vl=N with ready always high and a 1-cycle response: N+3 cycles from accept to done.
- reset_n mid-operation: immediate return to reset values. Late responses after reset are ignored (outstanding stays 0).

Test Plan:
- Unit-stride: mop=00, base=0x1000, sew=10, vl=4, ready=1, rsp 1 cycle later → addrs 0x1000,0x1004,0x1008,0x100C, be=4'hF, done at cycle 7.
- Byte packing: mop=00, base=0x2001, sew=00, vl=3 → addr 0x2000 be 0010, 0x2000 be 0100, 0x2000 be 1000.
- Strided negative: mop=10, base=0x100, stride=0xFFFFFFF8 (-8), sew=10, vl=3 → 0x100, 0xF8, 0xF0. Also stride so that addr wraps past 0xFFFFFFFC → modulo result.
- Indexed with backpressure: mop=01, base=0x4000, idx_offset {0x10,0x4,0x0}, mem_req_ready low 2 cycles on element 1 → addr held at 0x4004, elem_idx held at 1.
- Outstanding limit: MAX_OUTST=4, vl=8, no responses → exactly 4 requests, then valid=0. Release one response → one more request. done only after 8th response.
- Corners: vl=0 → done 2 cycles after accept, no requests. sew=11 → done+err. 16-bit at base 0x3001 → err, no request. reset_n low mid-ISSUE → all outputs at reset values immediately.

Source files
------------

// File: rtl/vec_lsu_addr_gen.sv
// Vector load address generator: walks elements 0..vl-1 of one decoded vector load,
// issues one word-aligned read per element with byte enables, and tracks responses.
module vec_lsu_addr_gen #(
  parameter int XLEN      = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [1:0]        ld_mop,
  input  logic [XLEN-1:0]   ld_base,
  input  logic [XLEN-1:0]   ld_stride,
  input  logic [1:0]        ld_sew,
  input  logic [XLEN-1:0]   ld_vl,
  output logic [XLEN-1:0]   elem_idx,
  input  logic [XLEN-1:0]   idx_offset,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_byte_en,
  input  logic              mem_rsp_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LANES = XLEN / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int CNT_W = $clog2(MAX_OUTST) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    DRAIN  = 2'b10,
    FINISH = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       mop_q;
  logic [1:0]       sew_q;
  logic [XLEN-1:0]  base_q;
  logic [XLEN-1:0]  stride_q;
  logic [XLEN-1:0]  vl_q;
  logic [XLEN-1:0]  acc_q;
  logic             err_q;
  logic [CNT_W-1:0] outst_q;

  logic [XLEN-1:0]  ea;
  logic [LANES-1:0] elem_mask;
  logic             misaligned;
  logic             accept;
  logic             req_fire;
  logic             rsp_take;
  logic             last_elem;

  assign accept    = ld_valid && ld_ready;
  assign req_fire  = mem_req_valid && mem_req_ready;
  // A response with nothing outstanding is stray and must not underflow the counter.
  assign rsp_take  = mem_rsp_valid && (outst_q != '0);
  assign last_elem = (elem_idx == vl_q - XLEN'(1));

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ea = base_q;
    case (mop_q)
      2'b00:   ea = base_q + (elem_idx << sew_q);
      2'b10:   ea = acc_q;
      default: ea = base_q + idx_offset;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    elem_mask  = '0;
    case (sew_q)
      2'b00: elem_mask[0] = 1'b1;
      2'b01: begin
        elem_mask[1:0] = '1;
        misaligned     = ea[0];
      end
      default: begin
        elem_mask[3:0] = '1;
        misaligned     = (ea[1:0] != 2'b00);
      end
    endcase
  end

  assign ld_ready      = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);
  assign err           = done && err_q;
  assign mem_req_valid = (state == ISSUE) && (outst_q < CNT_W'(MAX_OUTST)) && !misaligned;
  assign mem_addr      = mem_req_valid ? {ea[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_byte_en   = mem_req_valid ? (elem_mask << ea[OFF_W-1:0]) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = ((ld_vl == '0) || (ld_sew == 2'b11)) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (misaligned || (req_fire && last_elem))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((outst_q == '0) || ((outst_q == CNT_W'(1)) && rsp_take))
          state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // All command registers are reset too, so a mid-operation reset leaves no stale address on the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mop_q    <= '0;
      sew_q    <= '0;
      base_q   <= '0;
      stride_q <= '0;
      vl_q     <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      elem_idx <= '0;
    end else if (accept) begin
      mop_q    <= ld_mop;
      sew_q    <= ld_sew;
      base_q   <= ld_base;
      stride_q <= ld_stride;
      vl_q     <= ld_vl;
      acc_q    <= ld_base;
      err_q    <= (ld_sew == 2'b11);
      elem_idx <= '0;
    end else begin
      if (req_fire) begin
        elem_idx <= elem_idx + XLEN'(1);
        acc_q    <= acc_q + stride_q;
      end
      if ((state == ISSUE) && misaligned)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outst_q <= '0;
    end else begin
      case ({req_fire, rsp_take})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lsu_addr_gen.sv
// Self-checking bench for vec_lsu_addr_gen: directed corner cases plus randomized
// commands, checked against an element-list reference model and an in-order responder.
module tb_vec_lsu_addr_gen;

  localparam int XLEN      = 32;
  localparam int MAX_OUTST = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              ld_valid;
  logic              ld_ready;
  logic [1:0]        ld_mop;
  logic [XLEN-1:0]   ld_base;
  logic [XLEN-1:0]   ld_stride;
  logic [1:0]        ld_sew;
  logic [XLEN-1:0]   ld_vl;
  logic [XLEN-1:0]   elem_idx;
  logic [XLEN-1:0]   idx_offset;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_byte_en;
  logic              mem_rsp_valid;
  logic              busy;
  logic              done;
  logic              err;

  vec_lsu_addr_gen #(.XLEN(XLEN), .MAX_OUTST(MAX_OUTST)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_mop        (ld_mop),
    .ld_base       (ld_base),
    .ld_stride     (ld_stride),
    .ld_sew        (ld_sew),
    .ld_vl         (ld_vl),
    .elem_idx      (elem_idx),
    .idx_offset    (idx_offset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_byte_en   (mem_byte_en),
    .mem_rsp_valid (mem_rsp_valid),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] idx;
  } req_t;

  req_t        exp_q[$];
  logic        exp_err;
  logic [31:0] idx_tab [16];

  int n_vec     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int acc_cyc   = 0;
  int pending   = 0;
  int n_fired   = 0;
  int stalls    = 0;
  int bp_cnt    = 0;
  int credits   = 0;
  int stray     = 0;
  int ready_mode = 0;  // 0 always ready, 1 random, 2 stall element 1 twice
  int rsp_mode   = 0;  // 0 respond next cycle, 1 random delay, 2 only on credit

  always_comb idx_offset = (elem_idx < 32'd16) ? idx_tab[elem_idx[3:0]] : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory side: ready policy and in-order responder, driven just after each edge.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: mem_req_ready = 1'b1;
        1: mem_req_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (mem_req_valid && elem_idx == 32'd1 && bp_cnt < 2) begin
            mem_req_ready = 1'b0;
            bp_cnt++;
          end else begin
            mem_req_ready = 1'b1;
          end
        end
      endcase
      if (stray > 0) begin
        mem_rsp_valid = 1'b1;
        stray--;
      end else if (pending > 0 && (rsp_mode == 0 ||
                                   (rsp_mode == 1 && $urandom_range(0, 2) != 0) ||
                                   (rsp_mode == 2 && credits > 0))) begin
        mem_rsp_valid = 1'b1;
        if (rsp_mode == 2) credits--;
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  // Request monitor: every valid cycle must present the next expected element.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      int p;
      p = pending;
      if (mem_req_valid) begin
        check("outst_limit", 64'(pending < MAX_OUTST), 64'd1);
        if (exp_q.size() == 0) begin
          check("req_expected", 64'd0, 64'd1);
        end else begin
          check("req_addr", mem_addr, exp_q[0].addr);
          check("req_be", mem_byte_en, exp_q[0].be);
          check("req_idx", elem_idx, exp_q[0].idx);
          if (mem_req_ready) void'(exp_q.pop_front());
        end
        if (mem_req_ready) begin
          n_fired++;
          p++;
        end else begin
          stalls++;
        end
      end
      if (mem_rsp_valid && pending > 0) p--;
      pending = p;
    end
  end

  // Reference model: list every element's request straight from the addressing rules.
  task automatic build_model(input logic [1:0] mop, input logic [31:0] base,
                             input logic [31:0] stride, input logic [1:0] sew,
                             input logic [31:0] vl);
    exp_q.delete();
    exp_err = (sew == 2'b11);
    if (sew != 2'b11) begin
      for (int i = 0; i < int'(vl); i++) begin
        int          bytes;
        logic [31:0] ea;
        req_t        r;
        bytes = 1 << sew;
        case (mop)
          2'b00:   ea = base + 32'(i * bytes);
          2'b10:   ea = base + 32'(i) * stride;
          default: ea = base + idx_tab[i];
        endcase
        if ((ea % 32'(bytes)) != 0) begin
          exp_err = 1'b1;
          break;
        end
        r.addr = ea & ~32'h3;
        r.be   = 4'(((1 << bytes) - 1) << ea[1:0]);
        r.idx  = 32'(i);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic start_cmd(input logic [1:0] mop, input logic [31:0] base,
                           input logic [31:0] stride, input logic [1:0] sew,
                           input logic [31:0] vl);
    logic ok;
    build_model(mop, base, stride, sew, vl);
    n_fired = 0;
    stalls  = 0;
    @(posedge clk);
    #1;
    ld_mop    = mop;
    ld_base   = base;
    ld_stride = stride;
    ld_sew    = sew;
    ld_vl     = vl;
    ld_valid  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ld_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_seen", 64'(ok), 64'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
  endtask

  task automatic finish_cmd(input int exp_lat);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      check("err_without_done", 64'(err), 64'd0);
    end
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      if (exp_lat > 0) check("latency", 64'(cyc - acc_cyc + 1), 64'(exp_lat));
      check("err", 64'(err), 64'(exp_err));
      check("ready_in_finish", 64'(ld_ready), 64'd0);
      check("busy_in_finish", 64'(busy), 64'd1);
      check("missing_req", 64'(exp_q.size()), 64'd0);
      check("pending_at_done", 64'(pending), 64'd0);
      @(negedge clk);
      check("done_pulse", 64'(done), 64'd0);
      check("idle_ready", 64'(ld_ready), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  task automatic run_cmd(input logic [1:0] mop, input logic [31:0] base,
                         input logic [31:0] stride, input logic [1:0] sew,
                         input logic [31:0] vl, input int exp_lat);
    start_cmd(mop, base, stride, sew, vl);
    finish_cmd(exp_lat);
  endtask

  task automatic check_reset_values();
    check("rst_ld_ready", 64'(ld_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_elem_idx", elem_idx, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_byte_en", 64'(mem_byte_en), 64'd0);
  endtask

  initial begin
    reset_n   = 1'b1;
    ld_valid  = 1'b0;
    ld_mop    = '0;
    ld_base   = '0;
    ld_stride = '0;
    ld_sew    = '0;
    ld_vl     = '0;
    for (int i = 0; i < 16; i++) idx_tab[i] = '0;
    #3 reset_n = 1'b0;
    #1 check_reset_values();
    #18 reset_n = 1'b1;

    // Unit-stride words: four requests, done N+3 cycles after accept.
    ready_mode = 0; rsp_mode = 0;
    run_cmd(2'b00, 32'h1000, 32'h0, 2'b10, 32'd4, 7);

    // Byte packing into one word.
    run_cmd(2'b00, 32'h2001, 32'h0, 2'b00, 32'd3, 6);

    // Negative stride, then a stride that wraps past the top of the address space.
    run_cmd(2'b10, 32'h100, 32'hFFFF_FFF8, 2'b10, 32'd3, 6);
    run_cmd(2'b10, 32'hFFFF_FFF8, 32'h8, 2'b10, 32'd3, 6);

    // Indexed with two stall cycles on element 1.
    idx_tab[0] = 32'h10; idx_tab[1] = 32'h4; idx_tab[2] = 32'h0;
    ready_mode = 2; bp_cnt = 0;
    run_cmd(2'b01, 32'h4000, 32'h0, 2'b10, 32'd3, 8);
    check("bp_stalls", 64'(stalls), 64'd2);
    ready_mode = 0;

    // Outstanding limit: four requests, then nothing until a response frees a slot.
    rsp_mode = 2; credits = 0;
    start_cmd(2'b00, 32'h8000, 32'h0, 2'b10, 32'd8);
    repeat (10) @(negedge clk);
    check("limit_fired", 64'(n_fired), 64'd4);
    check("limit_valid_low", 64'(mem_req_valid), 64'd0);
    credits = 1;
    repeat (4) @(negedge clk);
    check("limit_one_more", 64'(n_fired), 64'd5);
    check("limit_not_done", 64'(done), 64'd0);
    credits = 100;
    finish_cmd(-1);
    check("limit_total", 64'(n_fired), 64'd8);
    rsp_mode = 0;

    // Corners: empty vector, illegal sew, misaligned first halfword.
    run_cmd(2'b00, 32'h1234, 32'h0, 2'b10, 32'd0, 2);
    check("vl0_no_req", 64'(n_fired), 64'd0);
    run_cmd(2'b00, 32'h1000, 32'h0, 2'b11, 32'd4, 2);
    check("sew3_no_req", 64'(n_fired), 64'd0);
    run_cmd(2'b00, 32'h3001, 32'h0, 2'b01, 32'd3, -1);
    check("misalign_no_req", 64'(n_fired), 64'd0);

    // Reset in the middle of ISSUE, then stray responses must be ignored.
    rsp_mode = 2; credits = 0;
    start_cmd(2'b00, 32'h5000, 32'h0, 2'b10, 32'd8);
    repeat (3) @(negedge clk);
    check("busy_mid_issue", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_values();
    exp_q.delete();
    pending = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    stray = 3;
    repeat (6) @(negedge clk);
    check("stray_busy", 64'(busy), 64'd0);
    rsp_mode = 0;
    run_cmd(2'b00, 32'h6000, 32'h0, 2'b10, 32'd2, 5);

    // Randomized commands with random backpressure and response delay.
    ready_mode = 1; rsp_mode = 1;
    for (int t = 0; t < 30; t++) begin
      logic [1:0]  mop, sew;
      logic [31:0] base, stride, vl, esz;
      mop  = 2'($urandom_range(0, 3));
      sew  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      vl   = 32'($urandom_range(0, 10));
      esz  = 32'd1 << sew;
      base = $urandom;
      if ($urandom_range(0, 3) != 0) base = base & ~(esz - 32'd1);
      stride = esz * 32'($urandom_range(0, 6) - 3);
      if ($urandom_range(0, 7) == 0) stride = stride + 32'd1;
      for (int i = 0; i < 16; i++) begin
        idx_tab[i] = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 15) != 0) idx_tab[i] = idx_tab[i] & ~(esz - 32'd1);
      end
      run_cmd(mop, base, stride, sew, vl, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
